// File: rtl/maxpool_reader.sv
// Read-side controller for the layer-1 conv ping-pong buffer: reads each 2-row bank in 2x2
// windows and emits the unsigned max of every window as one pooled pixel.
module maxpool_reader #(
    parameter int unsigned COLS    = 26,
    parameter int unsigned PAIRS   = 13,
    parameter int unsigned BANK_SZ = 52
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] i_bank_full,
    input  logic [7:0] i_rd_data,
    output logic       o_rd_en,
    output logic [6:0] o_rd_addr,
    output logic [1:0] o_bank_free,
    output logic [7:0] o_pool_out,
    output logic       o_pool_valid,
    output logic [3:0] o_pool_row,
    output logic [3:0] o_pool_col,
    output logic       o_pool_last
);

    localparam int unsigned WINS      = COLS / 2;
    localparam logic [3:0]  LAST_WIN  = 4'(WINS - 1);
    localparam logic [3:0]  LAST_PAIR = 4'(PAIRS - 1);

    typedef enum logic [1:0] {StIdle, StRead, StDrain, StDone} state_t;

    state_t     r_state, w_state_d;
    logic       r_cur, w_cur_d;
    logic [3:0] r_pair, w_pair_d;
    logic [3:0] r_win, w_win_d;
    logic [1:0] r_phase, w_phase_d;

    // Read-data pipeline: tags of the read issued last cycle, aligned with i_rd_data
    logic       r_dvld;
    logic [1:0] r_dphase;
    logic [3:0] r_dwin;
    logic [7:0] r_acc;
    logic [7:0] r_pool_out;
    logic       r_pool_valid;
    logic [3:0] r_pool_row;
    logic [3:0] r_pool_col;
    logic       r_pool_last;

    logic [6:0] w_base;
    logic [6:0] w_row_off;
    logic [6:0] w_col;
    logic [7:0] w_max;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= StIdle;
            r_cur   <= 1'b0;
            r_pair  <= 4'd0;
            r_win   <= 4'd0;
            r_phase <= 2'd0;
        end else begin
            r_state <= w_state_d;
            r_cur   <= w_cur_d;
            r_pair  <= w_pair_d;
            r_win   <= w_win_d;
            r_phase <= w_phase_d;
        end
    end

    always_comb begin
        w_state_d   = r_state;
        w_cur_d     = r_cur;
        w_pair_d    = r_pair;
        w_win_d     = r_win;
        w_phase_d   = r_phase;
        o_rd_en     = 1'b0;
        o_bank_free = 2'b00;
        unique case (r_state)
            StIdle: begin
                if (i_bank_full[r_cur]) begin
                    w_state_d = StRead;
                end
            end
            StRead: begin
                o_rd_en   = 1'b1;
                w_phase_d = r_phase + 2'd1;
                if (r_phase == 2'd3) begin
                    if (r_win == LAST_WIN) begin
                        w_win_d   = 4'd0;
                        w_state_d = StDrain;
                    end else begin
                        w_win_d = r_win + 4'd1;
                    end
                end
            end
            StDrain: begin
                w_state_d = StDone;
            end
            StDone: begin
                o_bank_free = r_cur ? 2'b10 : 2'b01;
                w_cur_d     = ~r_cur;
                w_pair_d    = (r_pair == LAST_PAIR) ? 4'd0 : r_pair + 4'd1;
                // bank_full drops during READ are ignored; only the next bank matters here
                w_state_d   = i_bank_full[~r_cur] ? StRead : StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    assign w_base    = r_cur ? 7'(BANK_SZ) : 7'd0;
    assign w_row_off = r_phase[1] ? 7'(COLS) : 7'd0;
    assign w_col     = {2'b00, r_win, 1'b0} + {6'd0, r_phase[0]};
    assign o_rd_addr = o_rd_en ? (w_base + w_row_off + w_col) : 7'd0;

    assign w_max = (i_rd_data > r_acc) ? i_rd_data : r_acc;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_dvld       <= 1'b0;
            r_dphase     <= 2'd0;
            r_dwin       <= 4'd0;
            r_acc        <= 8'd0;
            r_pool_out   <= 8'd0;
            r_pool_valid <= 1'b0;
            r_pool_row   <= 4'd0;
            r_pool_col   <= 4'd0;
            r_pool_last  <= 1'b0;
        end else begin
            r_dvld       <= o_rd_en;
            r_dphase     <= r_phase;
            r_dwin       <= r_win;
            r_pool_out   <= 8'd0;
            r_pool_valid <= 1'b0;
            r_pool_row   <= 4'd0;
            r_pool_col   <= 4'd0;
            r_pool_last  <= 1'b0;
            if (r_dvld) begin
                unique case (r_dphase)
                    2'd0: r_acc <= i_rd_data;
                    2'd1, 2'd2: r_acc <= w_max;
                    2'd3: begin
                        r_pool_out   <= w_max;
                        r_pool_valid <= 1'b1;
                        r_pool_row   <= r_pair;
                        r_pool_col   <= r_dwin;
                        r_pool_last  <= (r_pair == LAST_PAIR) && (r_dwin == LAST_WIN);
                    end
                    default: r_acc <= r_acc;
                endcase
            end
        end
    end

    assign o_pool_out   = r_pool_out;
    assign o_pool_valid = r_pool_valid;
    assign o_pool_row   = r_pool_row;
    assign o_pool_col   = r_pool_col;
    assign o_pool_last  = r_pool_last;

endmodule

// File: tb/tb_maxpool_reader.sv
// Directed bench for maxpool_reader: buffer model with 1-cycle latency, writer handshakes
// driven inline, expected values hand-derived from the window contents.
module tb_maxpool_reader;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [1:0] bank_full = 2'b00;
    logic [7:0] rd_data = 8'd0;
    logic       rd_en;
    logic [6:0] rd_addr;
    logic [1:0] bank_free;
    logic [7:0] pool_out;
    logic       pool_valid;
    logic [3:0] pool_row;
    logic [3:0] pool_col;
    logic       pool_last;

    logic [7:0] mem [0:103];
    logic [7:0] exp_b1 [0:12];

    int checks = 0;
    int errors = 0;

    maxpool_reader dut (
        .clk         (clk),
        .rst         (rst),
        .i_bank_full (bank_full),
        .i_rd_data   (rd_data),
        .o_rd_en     (rd_en),
        .o_rd_addr   (rd_addr),
        .o_bank_free (bank_free),
        .o_pool_out  (pool_out),
        .o_pool_valid(pool_valid),
        .o_pool_row  (pool_row),
        .o_pool_col  (pool_col),
        .o_pool_last (pool_last)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rd_data <= rd_en ? mem[rd_addr] : 8'd0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Address of read number k (0..51) within a bank
    function automatic logic [31:0] exp_addr(input int base, input int k);
        int w;
        int p;
        w = k / 4;
        p = k % 4;
        return base + ((p >= 2) ? 26 : 0) + 2 * w + (p % 2);
    endfunction

    int         nval, first, prev, freek, f0, f1;
    int         filled, nfree, nlast, lastidx;
    logic [1:0] freev, pend;
    logic [3:0] lrow, lcol;
    bit         got_next;

    initial begin
        for (int a = 0; a < 104; a++) mem[a] = 8'(a);

        // Reset held with both banks full
        rst = 1'b0;
        bank_full = 2'b11;
        repeat (3) step();
        chk("reset_rd", {rd_en, rd_addr, bank_free}, 0);
        chk("reset_pool", {pool_valid, pool_out, pool_row, pool_col, pool_last}, 0);
        rst = 1'b1;
        chk("release_idle", rd_en, 0);
        step();
        chk("release_rd_en", rd_en, 1);
        chk("release_addr", rd_addr, 0);

        rst = 1'b0;
        bank_full = 2'b00;
        step();
        step();
        rst = 1'b1;
        step();
        chk("idle_hold", rd_en, 0);

        // Single bank 0, mem[a] = a: window w max is 2w+27
        bank_full = 2'b01;
        nval = 0; first = 0; prev = 0; freek = 0; freev = 2'b00;
        for (int k = 1; k <= 56; k++) begin
            step();
            if (k <= 52) begin
                chk("b0_rd_en", rd_en, 1);
                chk("b0_addr", rd_addr, exp_addr(0, k - 1));
            end else begin
                chk("b0_rd_off", {rd_en, rd_addr}, 0);
            end
            if (pool_valid) begin
                nval++;
                if (nval == 1) first = k;
                else chk("b0_cadence", k - prev, 4);
                prev = k;
                chk("b0_row", pool_row, 0);
                chk("b0_col", pool_col, nval - 1);
                chk("b0_val", pool_out, 2 * (nval - 1) + 27);
                chk("b0_last", pool_last, 0);
            end
            if (bank_free != 2'b00) begin
                freek = k;
                freev = bank_free;
                bank_full = bank_full & ~bank_free;
            end
        end
        chk("b0_count", nval, 13);
        chk("b0_first_valid", first, 6);
        chk("b0_last_valid", prev, 54);
        chk("b0_free_cycle", freek, 54);
        chk("b0_free_val", freev, 1);

        // Bank 1: max of 200 in each phase position, plus an unsigned-compare window
        for (int a = 52; a < 104; a++) mem[a] = 8'd10;
        mem[52] = 8'd200;
        mem[55] = 8'd200;
        mem[82] = 8'd200;
        mem[85] = 8'd200;
        mem[62] = 8'd127;
        mem[63] = 8'd128;
        for (int w = 0; w < 13; w++) exp_b1[w] = 8'd10;
        for (int w = 0; w < 4; w++) exp_b1[w] = 8'd200;
        exp_b1[5] = 8'd128;
        bank_full = 2'b10;
        nval = 0; freek = 0; freev = 2'b00;
        for (int k = 1; k <= 56; k++) begin
            step();
            if (k == 1) chk("b1_first_addr", rd_addr, 52);
            if (k <= 52) chk("b1_addr", rd_addr, exp_addr(52, k - 1));
            if (pool_valid) begin
                nval++;
                chk("b1_row", pool_row, 1);
                chk("b1_val", pool_out, exp_b1[nval - 1]);
            end
            if (bank_free != 2'b00) begin
                freek = k;
                freev = bank_free;
                bank_full = bank_full & ~bank_free;
            end
        end
        chk("b1_count", nval, 13);
        chk("b1_free_cycle", freek, 54);
        chk("b1_free_val", freev, 2);

        // Back-to-back: both banks full, bank 1 read starts right after DONE
        for (int a = 0; a < 104; a++) mem[a] = 8'(a);
        bank_full = 2'b11;
        nval = 0; f0 = 0; f1 = 0;
        for (int k = 1; k <= 110; k++) begin
            step();
            if (k <= 52) begin
                chk("bb_rd0", {rd_en, rd_addr}, {1'b1, exp_addr(0, k - 1)[6:0]});
            end else if (k >= 55 && k <= 106) begin
                chk("bb_rd1", {rd_en, rd_addr}, {1'b1, exp_addr(52, k - 55)[6:0]});
            end else begin
                chk("bb_rd_off", rd_en, 0);
            end
            if (pool_valid) begin
                nval++;
                chk("bb_val", pool_out, ((nval - 1) / 13) * 52 + 2 * ((nval - 1) % 13) + 27);
                chk("bb_row", pool_row, 2 + (nval - 1) / 13);
            end
            if (bank_free == 2'b01) f0 = k;
            if (bank_free == 2'b10) f1 = k;
            bank_full = bank_full & ~bank_free;
        end
        chk("bb_count", nval, 26);
        chk("bb_free0", f0, 54);
        chk("bb_free1", f1, 108);

        // Reset in the middle of window 5
        bank_full = 2'b01;
        for (int k = 1; k <= 21; k++) step();
        chk("mid_addr_w5", rd_addr, 10);
        rst = 1'b0;
        bank_full = 2'b00;
        step();
        chk("mid_rst_rd", {rd_en, rd_addr, bank_free}, 0);
        chk("mid_rst_pool", {pool_valid, pool_out, pool_row, pool_col, pool_last}, 0);
        step();
        chk("mid_rst_hold", {rd_en, bank_free, pool_valid}, 0);
        rst = 1'b1;
        step();
        chk("mid_idle", {rd_en, bank_free, pool_valid}, 0);

        // Full frame with a writer that refills each bank the cycle after it is freed
        bank_full = 2'b11;
        filled = 2;
        pend = 2'b00;
        step();
        chk("restart_rd_en", rd_en, 1);
        chk("restart_addr", rd_addr, 0);
        nval = 0; nlast = 0; lastidx = 0; nfree = 0; lrow = 4'd0; lcol = 4'd0;
        got_next = 1'b0;
        for (int k = 2; k <= 800 && !got_next; k++) begin
            step();
            bank_full = bank_full | pend;
            pend = 2'b00;
            if (nfree == 13) begin
                chk("next_frame_en", rd_en, 1);
                chk("next_frame_addr", rd_addr, 52);
                got_next = 1'b1;
            end
            if (pool_valid) begin
                nval++;
                if (nval == 1) chk("frame_first_idx", {pool_row, pool_col}, 0);
                if (pool_last) begin
                    nlast++;
                    lastidx = nval;
                    lrow = pool_row;
                    lcol = pool_col;
                end
            end
            if (bank_free != 2'b00) begin
                nfree++;
                bank_full = bank_full & ~bank_free;
                if (filled < 14) begin
                    pend = pend | bank_free;
                    filled++;
                end
            end
        end
        chk("frame_reached_end", got_next, 1);
        chk("frame_valid_count", nval, 169);
        chk("frame_last_count", nlast, 1);
        chk("frame_last_index", lastidx, 169);
        chk("frame_last_row", lrow, 12);
        chk("frame_last_col", lcol, 12);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
